// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory controller.
// Contents:
//   ADDR_W_DFLT / DATA_W_DFLT / LEN_W_DFLT : default widths
//   RW_WRITE / RW_READ                     : request direction codes
//   state_t                                : controller FSM states
package mem_pkg;

  localparam int ADDR_W_DFLT = 16;
  localparam int DATA_W_DFLT = 32;
  localparam int LEN_W_DFLT  = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Signal bundle for the burst memory controller.
// Groups the request, write-stream, read-stream, memory and status signals.
//   master : the environment side (issues requests, supplies write words,
//            consumes read words, models the memory)
//   slave  : the controller side
interface mem_burst_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int LEN_W  = LEN_W_DFLT
);

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_rw, req_addr, req_len, wr_valid, wr_data,
           rd_ready, mem_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, mem_enable, mem_rw,
           mem_addr, mem_din, busy, done
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, wr_valid, wr_data,
           rd_ready, mem_dout,
    output req_ready, wr_ready, rd_valid, rd_data, mem_enable, mem_rw,
           mem_addr, mem_din, busy, done
  );

endinterface

// File: rtl/burst_counter.sv
// Address / remaining-word counter for one burst.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_addr / load_len (start of burst)
//   step       : advance one word (address +1, remaining -1)
//   addr       : current word address, wraps modulo 2^ADDR_W
//   remaining  : words still to be issued
//   zero       : remaining == 0
module burst_counter #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  remaining,
  output logic              zero
);

  // Address overflow simply rolls over; there is no error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign zero = (remaining == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: turns one request (address, length, direction)
// into a sequence of single-word memory accesses.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/ready/rw/addr/len  : burst request handshake
//   wr_valid/ready/data          : write-word stream into the controller
//   rd_valid/ready/data          : read-word stream out of the controller
//   mem_enable/rw/addr/din/dout  : single-port memory (dout combinational)
//   busy                         : burst in progress
//   done                         : one-cycle completion pulse
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int LEN_W  = LEN_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt_addr;
  logic [LEN_W-1:0]  cnt_remaining;
  logic              cnt_zero;
  logic              accept, wr_hs, rd_hs, rd_issue;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // req_ready is gated by rst so every output reads 0 during reset.
  assign req_ready = (state == IDLE) && !rst;
  assign wr_ready  = (state == WRITE) && !cnt_zero;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  assign accept = req_valid && req_ready;
  assign wr_hs  = wr_valid && wr_ready;
  assign rd_hs  = rd_valid && rd_ready;

  // A read is issued only when the output register is free this cycle,
  // so a stalled consumer never causes a word to be fetched twice.
  assign rd_issue = (state == READ) && !cnt_zero && (!rd_valid || rd_ready);

  burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (wr_hs || rd_issue),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (cnt_addr),
    .remaining (cnt_remaining),
    .zero      (cnt_zero)
  );

  // Writes go to memory one cycle after their handshake (registered);
  // reads are issued combinationally so mem_dout can be captured at the
  // end of the same cycle. When idle, mem_addr holds the last write address.
  assign mem_enable = wr_en_q || rd_issue;
  assign mem_rw     = rd_issue;
  assign mem_addr   = rd_issue ? cnt_addr : wr_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_len == '0)          state_nxt = DONE;
          else if (req_rw == RW_READ) state_nxt = READ;
          else                        state_nxt = WRITE;
        end
      end
      // Remaining reaches zero in the memory cycle of the last word.
      WRITE:   if (cnt_zero) state_nxt = DONE;
      READ:    if (cnt_zero && rd_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      mem_din   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      wr_en_q <= wr_hs;
      if (wr_hs) begin
        wr_addr_q <= cnt_addr;
        mem_din   <= wr_data;
      end
      if (rd_issue) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_dout;
      end else if (rd_hs) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: write/read bursts, read
// backpressure, address wrap, zero-length burst and reset mid-burst.
module tb_mem_burst_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  mem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (bus.req_valid),
    .req_ready  (bus.req_ready),
    .req_rw     (bus.req_rw),
    .req_addr   (bus.req_addr),
    .req_len    (bus.req_len),
    .wr_valid   (bus.wr_valid),
    .wr_ready   (bus.wr_ready),
    .wr_data    (bus.wr_data),
    .rd_valid   (bus.rd_valid),
    .rd_ready   (bus.rd_ready),
    .rd_data    (bus.rd_data),
    .mem_enable (bus.mem_enable),
    .mem_rw     (bus.mem_rw),
    .mem_addr   (bus.mem_addr),
    .mem_din    (bus.mem_din),
    .mem_dout   (bus.mem_dout),
    .busy       (bus.busy),
    .done       (bus.done)
  );

  // Memory model and activity monitors
  logic [DATA_W-1:0] mem [0:65535];
  assign bus.mem_dout = mem[bus.mem_addr];

  int cyc = 0, wr_count = 0, en_count = 0, dup_count = 0;
  int done_count = 0, last_done_cyc = -1;
  logic prev_en = 1'b0, prev_rw = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_enable) begin
      en_count <= en_count + 1;
      if (!bus.mem_rw) begin
        mem[bus.mem_addr] <= bus.mem_din;
        wr_count <= wr_count + 1;
      end
      if (prev_en && prev_addr == bus.mem_addr && prev_rw == bus.mem_rw)
        dup_count <= dup_count + 1;
    end
    prev_en   <= bus.mem_enable;
    prev_addr <= bus.mem_addr;
    prev_rw   <= bus.mem_rw;
  end

  always @(negedge clk) begin
    if (bus.done) begin
      done_count = done_count + 1;
      last_done_cyc = cyc;
    end
  end

  int n_checks = 0, n_fail = 0;
  logic [DATA_W-1:0] feed_q[$];
  logic [DATA_W-1:0] rx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic do_req(input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [LEN_W-1:0] len, output int acc);
    int g = 0;
    while (!bus.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_len   = len;
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic feed_words(output int last_hs);
    int i = 0, g = 0;
    logic hs;
    last_hs = -1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = feed_q[0];
    while (i < feed_q.size() && g < 100) begin
      hs = bus.wr_ready;
      if (hs) last_hs = cyc;
      @(negedge clk);
      g++;
      if (hs) begin
        i++;
        if (i < feed_q.size()) bus.wr_data = feed_q[i];
      end
    end
    bus.wr_valid = 1'b0;
    check("write_all_accepted", i, feed_q.size());
  endtask

  task automatic read_words(input int n, input bit bp, output int first_v, output int last_hs);
    int k = 0, g = 0;
    bit held = 0;
    logic [DATA_W-1:0] held_data = '0;
    logic [3:0] pat = 4'b1001;
    first_v = -1;
    last_hs = -1;
    rx_q.delete();
    while (rx_q.size() < n && g < 200) begin
      bus.rd_ready = bp ? pat[k % 4] : 1'b1;
      #1;
      if (held) begin
        check("bp_hold_valid", bus.rd_valid, 1);
        check("bp_hold_data", bus.rd_data, held_data);
      end
      held = 0;
      if (bus.rd_valid && first_v < 0) first_v = cyc;
      if (bus.rd_valid && !bus.rd_ready) begin
        check("bp_mem_idle", bus.mem_enable, 0);
        held = 1;
        held_data = bus.rd_data;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        rx_q.push_back(bus.rd_data);
        last_hs = cyc;
      end
      @(negedge clk);
      k++;
      g++;
    end
    bus.rd_ready = 1'b0;
    check("read_word_count", rx_q.size(), n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  bus.req_ready, 0);
    check({tag, "_wr_ready"},   bus.wr_ready, 0);
    check({tag, "_rd_valid"},   bus.rd_valid, 0);
    check({tag, "_rd_data"},    bus.rd_data, 0);
    check({tag, "_mem_enable"}, bus.mem_enable, 0);
    check({tag, "_mem_rw"},     bus.mem_rw, 0);
    check({tag, "_mem_addr"},   bus.mem_addr, 0);
    check({tag, "_mem_din"},    bus.mem_din, 0);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_done"},       bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t wvec[8];
    vec_t wrapvec[4];
    int acc, last_hs, first_v, en0, d0, w0, i, g;
    logic hs;

    // Write burst table: address and expected memory contents
    wvec[0] = '{16'h0000, 32'h0000AAAA};
    wvec[1] = '{16'h0001, 32'h000000AA};
    wvec[2] = '{16'h0002, 32'h000000BB};
    wvec[3] = '{16'h0003, 32'h000000CC};
    wvec[4] = '{16'h0004, 32'h000000DD};
    wvec[5] = '{16'h0005, 32'h000000EE};
    wvec[6] = '{16'h0006, 32'h000000FF};
    wvec[7] = '{16'h0007, 32'h0000FFFF};
    // Wrap burst starting at FFFE
    wrapvec[0] = '{16'hFFFE, 32'hC0DE0000};
    wrapvec[1] = '{16'hFFFF, 32'hC0DE0001};
    wrapvec[2] = '{16'h0000, 32'hC0DE0002};
    wrapvec[3] = '{16'h0001, 32'hC0DE0003};

    for (int a = 0; a < 65536; a++) mem[a] = '0;
    bus.req_valid = 0; bus.req_rw = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("req_ready_after_reset", bus.req_ready, 1);
    @(negedge clk);

    // Write burst: addr 0, len 8
    en0 = en_count; d0 = done_count;
    feed_q.delete();
    foreach (wvec[k]) feed_q.push_back(wvec[k].data);
    do_req(RW_WRITE, 16'h0000, 8'd8, acc);
    check("wr_busy", bus.busy, 1);
    feed_words(last_hs);
    @(negedge clk); #2;
    check("wr_done_cycle", last_done_cyc, last_hs + 2);
    @(negedge clk); #2;
    for (int k = 0; k < 8; k++) check("wr_mem_word", mem[wvec[k].addr], wvec[k].data);
    check("wr_enable_count", en_count - en0, 8);
    check("wr_no_dup_enable", dup_count, 0);
    check("wr_done_pulses", done_count - d0, 1);
    check("wr_idle_busy", bus.busy, 0);

    // Read burst with rd_ready held high
    en0 = en_count; d0 = done_count;
    do_req(RW_READ, 16'h0000, 8'd8, acc);
    read_words(8, 1'b0, first_v, last_hs);
    #2;
    check("rd_first_valid_latency", first_v - acc, 2);
    check("rd_consecutive_beats", last_hs - first_v, 7);
    for (int k = 0; k < 8; k++) check("rd_data_seq", rx_q[k], wvec[k].data);
    check("rd_done_cycle", last_done_cyc, last_hs + 1);
    @(negedge clk); #2;
    check("rd_enable_count", en_count - en0, 8);
    check("rd_done_pulses", done_count - d0, 1);

    // Read with backpressure pattern 1,0,0,1
    en0 = en_count;
    do_req(RW_READ, 16'h0000, 8'd8, acc);
    read_words(8, 1'b1, first_v, last_hs);
    for (int k = 0; k < 8; k++) check("bp_data_seq", rx_q[k], wvec[k].data);
    @(negedge clk); #2;
    check("bp_enable_count", en_count - en0, 8);
    check("bp_no_dup_enable", dup_count, 0);

    // Address wrap
    feed_q.delete();
    foreach (wrapvec[k]) feed_q.push_back(wrapvec[k].data);
    do_req(RW_WRITE, 16'hFFFE, 8'd4, acc);
    feed_words(last_hs);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) check("wrap_mem_word", mem[wrapvec[k].addr], wrapvec[k].data);
    check("wrap_no_spill", mem[16'h0002], 32'h000000BB);

    // Zero-length burst
    en0 = en_count; d0 = done_count;
    do_req(RW_WRITE, 16'h0010, 8'd0, acc);
    #2;
    check("zero_done_now", bus.done, 1);
    check("zero_done_cycle", last_done_cyc, acc + 1);
    @(negedge clk); #2;
    check("zero_no_enable", en_count - en0, 0);
    check("zero_done_pulses", done_count - d0, 1);
    check("zero_idle", bus.busy, 0);

    // Reset during a len-8 write, after three memory writes
    w0 = wr_count; d0 = done_count;
    do_req(RW_WRITE, 16'h0100, 8'd8, acc);
    i = 0; g = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1000;
    while (wr_count - w0 < 3 && g < 50) begin
      hs = bus.wr_ready;
      @(negedge clk);
      g++;
      if (hs) begin
        i++;
        bus.wr_data = 32'h1000 + i;
      end
    end
    check("rst_three_written", wr_count - w0, 3);
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    check("midrst_write_count", wr_count - w0, 3);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_word2", mem[16'h0102], 32'h1002);
    check("midrst_word3_untouched", mem[16'h0103], 32'h0);
    rst = 1'b0;
    #1 check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
